if_fetch_ctrl: RTL and testbench

//  Fetch-stage controller. Owns the PC register, drives the instruction memory's

---
 rtl/if_fetch_ctrl.sv | 86 ++++++++
 tb/tb_if_fetch_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch-stage controller: PC register, IMEM address, IF/ID register, boot hold and halt detect
module if_fetch_ctrl #(
  parameter int          IMEM_BYTES  = 192,
  parameter int          BOOT_CYCLES = 2,
  parameter int          HALT_EN     = 1,
  parameter logic [31:0] HALT_WORD   = 32'hEAFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        halted
);

  localparam logic [1:0]  ST_BOOT   = 2'd0;
  localparam logic [1:0]  ST_RUN    = 2'd1;
  localparam logic [1:0]  ST_HALT   = 2'd2;
  localparam logic [31:0] IMEM_SIZE = 32'(IMEM_BYTES);
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES);

  logic [1:0]  state;
  logic [3:0]  boot_cnt;
  logic [31:0] pc_inc;
  logic [31:0] pc_seq;
  logic [31:0] br_target;
  logic        run_now;
  logic        is_halt_word;

  assign pc_inc       = pc_out + 32'd4;
  assign pc_seq       = (pc_inc >= IMEM_SIZE) ? 32'd0 : pc_inc;
  assign br_target    = {branch_addr[31:2], 2'b00} % IMEM_SIZE;
  assign is_halt_word = (HALT_EN != 0) && (instr_in == HALT_WORD);

  // The edge that completes the boot count already behaves as a RUN edge,
  // so BOOT_CYCLES=0 fetches on the very first edge after reset release.
  assign run_now = (state == ST_RUN) || ((state == ST_BOOT) && (boot_cnt == BOOT_LAST));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_BOOT;
      boot_cnt <= 4'd0;
      pc_out   <= 32'd0;
      id_pc    <= 32'd0;
      id_instr <= 32'd0;
      id_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (run_now) begin
      state <= ST_RUN;
      if (branch_taken) begin
        pc_out   <= br_target;
        id_pc    <= 32'd0;
        id_instr <= 32'd0;
        id_valid <= 1'b0;
      end else if (!freeze) begin
        id_pc    <= pc_inc;
        id_instr <= instr_in;
        id_valid <= 1'b1;
        // The terminal self-loop word is delivered to ID but the PC parks on it.
        if (is_halt_word) begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end else begin
          pc_out <= pc_seq;
        end
      end
    end else if (state == ST_BOOT) begin
      boot_cnt <= boot_cnt + 4'd1;
      pc_out   <= 32'd0;
      id_pc    <= 32'd0;
      id_instr <= 32'd0;
      id_valid <= 1'b0;
    end else begin
      halted   <= 1'b1;
      id_pc    <= 32'd0;
      id_instr <= 32'd0;
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed vector bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  localparam logic [31:0] HALT_W = 32'hEAFFFFFF;

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] idpc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr, pc_out, instr_in, id_pc, id_instr;
  logic        id_valid, halted;

  logic        rst2, freeze2, branch_taken2;
  logic [31:0] branch_addr2, pc_out2, instr_in2, id_pc2, id_instr2;
  logic        id_valid2, halted2;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vt[19];

  always #5 clk = ~clk;

  // Word k of the test program is 0x1000_0000+k, except the halt word at byte 184.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w == 32'd46) ? HALT_W : (32'h1000_0000 + w);
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] ad,
                              input logic [31:0] p, input logic [31:0] ip, input logic [31:0] ins,
                              input logic v, input logic h);
    vec_t t;
    t.rst = r; t.frz = f; t.br = b; t.addr = ad;
    t.pc = p; t.idpc = ip; t.instr = ins; t.valid = v; t.halted = h;
    return t;
  endfunction

  assign instr_in  = mem_word(pc_out);
  assign instr_in2 = mem_word(pc_out2);

  if_fetch_ctrl #(.IMEM_BYTES(192), .BOOT_CYCLES(2), .HALT_EN(1), .HALT_WORD(HALT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .pc_out(pc_out), .instr_in(instr_in), .id_pc(id_pc),
    .id_instr(id_instr), .id_valid(id_valid), .halted(halted)
  );

  if_fetch_ctrl #(.IMEM_BYTES(16), .BOOT_CYCLES(0), .HALT_EN(0), .HALT_WORD(HALT_W)) dut_small (
    .clk(clk), .rst(rst2), .freeze(freeze2), .branch_taken(branch_taken2),
    .branch_addr(branch_addr2), .pc_out(pc_out2), .instr_in(instr_in2), .id_pc(id_pc2),
    .id_instr(id_instr2), .id_valid(id_valid2), .halted(halted2)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    logic found;

    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    rst2 = 1'b0; freeze2 = 1'b0; branch_taken2 = 1'b0; branch_addr2 = '0;

    //            rst frz br addr          pc       id_pc    id_instr                 v  h
    vt[0]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,                   0, 0);
    vt[1]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,                   0, 0);
    vt[2]  = mk(1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,                   0, 0);
    vt[3]  = mk(1, 1, 1, 32'h40,  32'h0,   32'h0,   32'h0,                   0, 0);
    vt[4]  = mk(1, 0, 0, 32'h0,   32'h4,   32'h4,   32'h1000_0000,           1, 0);
    vt[5]  = mk(1, 0, 0, 32'h0,   32'h8,   32'h8,   32'h1000_0001,           1, 0);
    vt[6]  = mk(1, 1, 0, 32'h0,   32'h8,   32'h8,   32'h1000_0001,           1, 0);
    vt[7]  = mk(1, 1, 0, 32'h0,   32'h8,   32'h8,   32'h1000_0001,           1, 0);
    vt[8]  = mk(1, 1, 0, 32'h0,   32'h8,   32'h8,   32'h1000_0001,           1, 0);
    vt[9]  = mk(1, 0, 0, 32'h0,   32'hC,   32'hC,   32'h1000_0002,           1, 0);
    vt[10] = mk(1, 1, 1, 32'h47,  32'h44,  32'h0,   32'h0,                   0, 0);
    vt[11] = mk(1, 0, 0, 32'h0,   32'h48,  32'h48,  32'h1000_0011,           1, 0);
    vt[12] = mk(1, 0, 1, 32'hBE,  32'hBC,  32'h0,   32'h0,                   0, 0);
    vt[13] = mk(1, 0, 0, 32'h0,   32'h0,   32'hC0,  32'h1000_002F,           1, 0);
    vt[14] = mk(1, 0, 1, 32'h104, 32'h44,  32'h0,   32'h0,                   0, 0);
    vt[15] = mk(0, 0, 1, 32'h20,  32'h0,   32'h0,   32'h0,                   0, 0);
    vt[16] = mk(1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,                   0, 0);
    vt[17] = mk(1, 0, 1, 32'h20,  32'h0,   32'h0,   32'h0,                   0, 0);
    vt[18] = mk(1, 0, 0, 32'h0,   32'h4,   32'h4,   32'h1000_0000,           1, 0);

    for (int i = 0; i < 19; i++) begin
      rst = vt[i].rst; freeze = vt[i].frz; branch_taken = vt[i].br; branch_addr = vt[i].addr;
      step();
      chk("pc_out",   i, pc_out,          vt[i].pc);
      chk("id_pc",    i, id_pc,           vt[i].idpc);
      chk("id_instr", i, id_instr,        vt[i].instr);
      chk("id_valid", i, {31'd0, id_valid}, {31'd0, vt[i].valid});
      chk("halted",   i, {31'd0, halted},   {31'd0, vt[i].halted});
    end

    // Run the program to its terminal word and confirm HALT is sticky until reset.
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    step();
    rst = 1'b1;
    edges = 0;
    found = 1'b0;
    while (!found && edges < 120) begin
      step();
      edges++;
      if (id_valid && id_instr == HALT_W) found = 1'b1;
    end
    chk("halt_edges", 0, 32'(edges), 32'd49);
    chk("halt_pc",    0, pc_out, 32'd184);
    chk("halt_idpc",  0, id_pc, 32'd188);
    for (int k = 1; k <= 3; k++) begin
      branch_taken = (k != 2);
      branch_addr  = 32'h10;
      step();
      chk("halt_pc",     k, pc_out, 32'd184);
      chk("halt_instr",  k, id_instr, 32'h0);
      chk("halt_valid",  k, {31'd0, id_valid}, 32'd0);
      chk("halted",      k, {31'd0, halted}, 32'd1);
    end
    rst = 1'b0; branch_taken = 1'b1;
    step();
    chk("halt_rst_pc",     0, pc_out, 32'd0);
    chk("halt_rst_halted", 0, {31'd0, halted}, 32'd0);
    rst = 1'b1; branch_taken = 1'b0;

    // Small 16-byte memory with no boot delay: sequential fetch and wrap.
    rst2 = 1'b0;
    step();
    chk("small_rst_pc", 0, pc_out2, 32'd0);
    rst2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("small_pc",    k, pc_out2, (32'(k + 1) * 32'd4) % 32'd16);
      chk("small_idpc",  k, id_pc2, ((32'(k) * 32'd4) % 32'd16) + 32'd4);
      chk("small_instr", k, id_instr2, 32'h1000_0000 + (32'(k) % 32'd4));
      chk("small_valid", k, {31'd0, id_valid2}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
